// File: rtl/dma_priority_arbiter_pkg.sv
// Package shared by the DMA priority arbiter slice.
// Holds the default channel count, the channel index type and the
// arbiter state encoding used by the arbiter FSM.
package dma_pkg;

  localparam int DEFAULT_NUM_CHANNELS = 4;
  localparam int DEFAULT_CH_W         = $clog2(DEFAULT_NUM_CHANNELS);

  typedef logic [DEFAULT_CH_W-1:0] chan_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    GRANTED = 2'd2,
    ACTIVE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Interface bundling the DREQ/DACK pins, the CPU hold handshake, the
// timing-and-control pulses and the command/mask register bits seen by
// the DMA priority arbiter.
//   master : environment side (drives requests, HLDA, pulses, command bits)
//   slave  : arbiter side (drives HRQ, DACK, activeChannel, channelGranted)
interface dma_priority_arbiter_if
  import dma_pkg::*;
#(
  parameter int NUM_CHANNELS = DEFAULT_NUM_CHANNELS
);
  localparam int CH_W = $clog2(NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0] DREQ;
  logic                    HLDA;
  logic                    assertDACK;
  logic                    deassertDACK;
  logic [NUM_CHANNELS-1:0] maskReg;
  logic                    rotatingPriority;
  logic                    dreqSenseLow;
  logic                    dackSenseHigh;
  logic                    HRQ;
  logic [NUM_CHANNELS-1:0] DACK;
  logic [CH_W-1:0]         activeChannel;
  logic                    channelGranted;

  modport master (
    output DREQ, HLDA, assertDACK, deassertDACK, maskReg,
           rotatingPriority, dreqSenseLow, dackSenseHigh,
    input  HRQ, DACK, activeChannel, channelGranted
  );

  modport slave (
    input  DREQ, HLDA, assertDACK, deassertDACK, maskReg,
           rotatingPriority, dreqSenseLow, dackSenseHigh,
    output HRQ, DACK, activeChannel, channelGranted
  );

endinterface

// File: rtl/dma_priority_arbiter_encoder.sv
// Combinational priority encoder for the DMA arbiter.
//   eff_req           : effective (polarity-corrected, unmasked) requests
//   pri_ptr           : first channel searched in rotating mode
//   rotating_priority : 1 = search from pri_ptr with wrap, 0 = lowest index wins
//   winner            : index of the winning channel
//   valid             : at least one effective request present
module dma_priority_encoder #(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] eff_req,
  input  logic [CH_W-1:0]         pri_ptr,
  input  logic                    rotating_priority,
  output logic [CH_W-1:0]         winner,
  output logic                    valid
);

  logic [CH_W-1:0] start_s;
  logic [CH_W-1:0] idx_s;
  int              idx_i;

  // Walk the channels starting at start_s, wrapping, and keep the first hit.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx_i  = 0;
    idx_s  = '0;
    if (rotating_priority) begin
      start_s = pri_ptr;
    end else begin
      start_s = '0;
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      idx_i = int'(start_s) + i;
      if (idx_i >= NUM_CHANNELS) begin
        idx_i = idx_i - NUM_CHANNELS;
      end else begin
        idx_i = idx_i;
      end
      idx_s = idx_i[CH_W-1:0];
      if (!valid && eff_req[idx_s]) begin
        valid  = 1'b1;
        winner = idx_s;
      end else begin
        valid  = valid;
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA priority arbiter: arbitrates DREQ lines, raises HRQ to the CPU,
// waits for HLDA, latches the winning channel and drives its DACK on
// command from timing-and-control.
//   CLK   : system clock
//   RESET : asynchronous active-high reset
//   bus   : slave side of dma_priority_arbiter_if (pins, handshake, command bits)
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CHANNELS = DEFAULT_NUM_CHANNELS,
  parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  dma_priority_arbiter_if.slave  bus
);

  arb_state_t              state_r, state_s;
  logic [CH_W-1:0]         active_r, active_s;
  logic [CH_W-1:0]         pri_ptr_r, pri_ptr_s;
  logic [NUM_CHANNELS-1:0] ack_r, ack_s;
  logic                    hrq_r;
  logic                    granted_r;
  logic [NUM_CHANNELS-1:0] eff_req_s;
  logic [CH_W-1:0]         winner_s;
  logic                    win_valid_s;

  // Effective request: polarity-corrected DREQ with masked channels removed.
  always_comb begin
    if (bus.dreqSenseLow) begin
      eff_req_s = ~bus.DREQ & ~bus.maskReg;
    end else begin
      eff_req_s = bus.DREQ & ~bus.maskReg;
    end
  end

  dma_priority_encoder #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CH_W         (CH_W)
  ) u_encoder (
    .eff_req           (eff_req_s),
    .pri_ptr           (pri_ptr_r),
    .rotating_priority (bus.rotatingPriority),
    .winner            (winner_s),
    .valid             (win_valid_s)
  );

  // Next-state logic; the channel is only re-arbitrated while IDLE.
  always_comb begin
    state_s   = state_r;
    active_s  = active_r;
    pri_ptr_s = pri_ptr_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) begin
          state_s  = REQUEST;
          active_s = winner_s;
        end else begin
          state_s  = IDLE;
        end
      end
      REQUEST: begin
        if (bus.HLDA) begin
          state_s = GRANTED;
        end else if (!eff_req_s[active_r]) begin
          state_s = IDLE;
        end else begin
          state_s = REQUEST;
        end
      end
      GRANTED: begin
        // assertDACK wins over a simultaneous deassertDACK here.
        if (!bus.HLDA) begin
          state_s = IDLE;
        end else if (bus.assertDACK) begin
          state_s = ACTIVE;
        end else begin
          state_s = GRANTED;
        end
      end
      ACTIVE: begin
        // HLDA loss aborts without touching the rotation pointer.
        if (!bus.HLDA) begin
          state_s = IDLE;
        end else if (bus.deassertDACK) begin
          state_s = IDLE;
          if (!bus.rotatingPriority) begin
            pri_ptr_s = pri_ptr_r;
          end else if (active_r == CH_W'(NUM_CHANNELS - 1)) begin
            pri_ptr_s = '0;
          end else begin
            pri_ptr_s = active_r + CH_W'(1);
          end
        end else begin
          state_s = ACTIVE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // One-hot acknowledge vector for the next cycle.
  always_comb begin
    ack_s = '0;
    if (state_s == ACTIVE) begin
      ack_s[active_s] = 1'b1;
    end else begin
      ack_s = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= IDLE;
      active_r  <= '0;
      pri_ptr_r <= '0;
      ack_r     <= '0;
      hrq_r     <= 1'b0;
      granted_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      active_r  <= active_s;
      pri_ptr_r <= pri_ptr_s;
      ack_r     <= ack_s;
      hrq_r     <= (state_s != IDLE);
      granted_r <= (state_s == GRANTED) || (state_s == ACTIVE);
    end
  end

  assign bus.HRQ            = hrq_r;
  assign bus.channelGranted = granted_r;
  assign bus.activeChannel  = active_r;
  // Polarity is applied after the register so a command change acts at once.
  assign bus.DACK           = bus.dackSenseHigh ? ack_r : ~ack_r;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed scenarios plus a
// randomized run, all compared against a service-level reference model.
module tb_dma_priority_arbiter;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  dma_priority_arbiter_if #(.NUM_CHANNELS(4)) bus ();

  dma_priority_arbiter #(.NUM_CHANNELS(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  // phase: 0 no service, 1 waiting for HLDA, 2 granted, 3 DACK driven
  int         m_phase;
  int         m_ch;
  int         m_ptr;
  logic [3:0] m_eff;
  logic [3:0] m_ack;
  logic [3:0] m_dack;
  logic [1:0] m_ch_v;
  logic [7:0] exp_vec;
  logic [7:0] obs;

  function automatic int model_winner(input logic [3:0] eff, input int start);
    logic [7:0] dbl;
    int k;
    dbl = {eff, eff} >> start;
    k = 0;
    while (k < 4 && !dbl[k]) k++;
    return (start + k) % 4;
  endfunction

  assign m_eff = (bus.dreqSenseLow ? ~bus.DREQ : bus.DREQ) & ~bus.maskReg;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_phase <= 0;
      m_ch    <= 0;
      m_ptr   <= 0;
    end else if (m_phase == 0) begin
      if (m_eff != 4'b0000) begin
        m_phase <= 1;
        m_ch    <= model_winner(m_eff, bus.rotatingPriority ? m_ptr : 0);
      end
    end else if (!bus.HLDA && m_phase >= 2) begin
      m_phase <= 0;
    end else if (m_phase == 1) begin
      if (bus.HLDA) m_phase <= 2;
      else if (!m_eff[m_ch]) m_phase <= 0;
    end else if (m_phase == 2) begin
      if (bus.assertDACK) m_phase <= 3;
    end else if (bus.deassertDACK) begin
      m_phase <= 0;
      if (bus.rotatingPriority) m_ptr <= (m_ch + 1) % 4;
    end
  end

  always_comb begin
    m_ch_v  = m_ch[1:0];
    m_ack   = (m_phase == 3) ? (4'b0001 << m_ch) : 4'b0000;
    m_dack  = bus.dackSenseHigh ? m_ack : ~m_ack;
    exp_vec = {(m_phase != 0), (m_phase >= 2), m_ch_v, m_dack};
  end

  assign obs = {bus.HRQ, bus.channelGranted, bus.activeChannel, bus.DACK};

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic set_idle_inputs();
    bus.DREQ             = 4'b0000;
    bus.HLDA             = 1'b0;
    bus.assertDACK       = 1'b0;
    bus.deassertDACK     = 1'b0;
    bus.maskReg          = 4'b0000;
    bus.rotatingPriority = 1'b0;
    bus.dreqSenseLow     = 1'b0;
    bus.dackSenseHigh    = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    set_idle_inputs();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET = 1'b1;
    set_idle_inputs();
    @(negedge CLK);
    #1;
    checks++;
    if (obs !== 8'h0F) begin
      errors++;
      $display("FAIL reset_low: got %h exp %h", obs, 8'h0F);
    end
    bus.dackSenseHigh = 1'b1;
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_high: got %h exp %h", obs, 8'h00);
    end
    checks++;
    if (obs !== exp_vec) begin
      errors++;
      $display("FAIL reset_model: got %h exp %h", obs, exp_vec);
    end
    bus.dackSenseHigh = 1'b0;
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_fixed();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      bus.assertDACK   = 1'b0;
      bus.deassertDACK = 1'b0;
      case (c)
        0:  bus.DREQ = 4'b0110;
        3:  bus.HLDA = 1'b1;
        5:  bus.assertDACK = 1'b1;
        8:  bus.deassertDACK = 1'b1;
        10: begin bus.DREQ = 4'b0000; bus.HLDA = 1'b0; end
        default: ;
      endcase
      @(negedge CLK);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL fixed_model c=%0d: got %h exp %h", c, obs, exp_vec);
      end
      if (c == 0 || c == 9) begin
        checks++;
        if (bus.HRQ !== 1'b1) begin
          errors++;
          $display("FAIL fixed_hrq_rise c=%0d: got %b exp 1", c, bus.HRQ);
        end
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (bus.channelGranted !== (c == 3)) begin
          errors++;
          $display("FAIL fixed_granted c=%0d: got %b exp %b", c, bus.channelGranted, (c == 3));
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.DACK !== 4'b1101 || bus.activeChannel !== 2'd1) begin
          errors++;
          $display("FAIL fixed_dack: got %b/%0d exp 1101/1", bus.DACK, bus.activeChannel);
        end
      end
      if (c == 8) begin
        checks++;
        if (bus.DACK !== 4'hF || bus.HRQ !== 1'b0) begin
          errors++;
          $display("FAIL fixed_end: got %b/%b exp 1111/0", bus.DACK, bus.HRQ);
        end
      end
    end
  endtask

  task automatic test_rotating();
    int order [5];
    order = '{0, 1, 2, 3, 0};
    do_reset();
    bus.rotatingPriority = 1'b1;
    bus.DREQ             = 4'b1111;
    bus.HLDA             = 1'b1;
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 4; c++) begin
        bus.assertDACK   = (c == 2);
        bus.deassertDACK = (c == 3);
        @(negedge CLK);
        checks++;
        if (obs !== exp_vec) begin
          errors++;
          $display("FAIL rot_model s=%0d c=%0d: got %h exp %h", s, c, obs, exp_vec);
        end
        if (c == 2) begin
          checks++;
          if (int'(bus.activeChannel) !== order[s]) begin
            errors++;
            $display("FAIL rot_order s=%0d: got %0d exp %0d", s, bus.activeChannel, order[s]);
          end
        end
      end
    end
    bus.assertDACK   = 1'b0;
    bus.deassertDACK = 1'b0;
  endtask

  task automatic test_mask_polarity();
    do_reset();
    bus.maskReg       = 4'b0001;
    bus.dreqSenseLow  = 1'b1;
    bus.dackSenseHigh = 1'b1;
    bus.DREQ          = 4'b1100;
    bus.HLDA          = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.assertDACK   = (c == 2);
      bus.deassertDACK = (c == 3);
      @(negedge CLK);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL mask_model c=%0d: got %h exp %h", c, obs, exp_vec);
      end
      if (c == 2) begin
        checks++;
        if (bus.DACK !== 4'b0010 || bus.activeChannel !== 2'd1) begin
          errors++;
          $display("FAIL mask_dack: got %b/%0d exp 0010/1", bus.DACK, bus.activeChannel);
        end
      end
    end
    bus.deassertDACK = 1'b0;
  endtask

  task automatic test_withdraw();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus.DREQ = (c < 2) ? 4'b0100 : 4'b0000;
      @(negedge CLK);
      checks++;
      if (obs !== exp_vec || bus.DACK !== 4'hF) begin
        errors++;
        $display("FAIL withdraw c=%0d: got %h exp %h", c, obs, exp_vec);
      end
      if (c == 0 || c == 2) begin
        checks++;
        if (bus.HRQ !== (c == 0)) begin
          errors++;
          $display("FAIL withdraw_hrq c=%0d: got %b exp %b", c, bus.HRQ, (c == 0));
        end
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    bus.rotatingPriority = 1'b1;
    bus.HLDA             = 1'b1;
    bus.DREQ             = 4'b0010;
    for (int c = 0; c < 11; c++) begin
      bus.assertDACK   = (c == 2 || c == 6);
      bus.deassertDACK = (c == 3);
      if (c == 3) bus.DREQ = 4'b1000;
      if (c == 7) bus.HLDA = 1'b0;
      if (c == 8) begin bus.HLDA = 1'b1; bus.DREQ = 4'b1111; end
      @(negedge CLK);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL abort_model c=%0d: got %h exp %h", c, obs, exp_vec);
      end
      if (c == 6) begin
        checks++;
        if (bus.DACK !== 4'b0111 || bus.activeChannel !== 2'd3) begin
          errors++;
          $display("FAIL abort_active: got %b/%0d exp 0111/3", bus.DACK, bus.activeChannel);
        end
      end
      if (c == 7) begin
        checks++;
        if (obs !== 8'h3F) begin
          errors++;
          $display("FAIL abort_drop: got %h exp %h", obs, 8'h3F);
        end
      end
      if (c == 8) begin
        checks++;
        if (bus.activeChannel !== 2'd2) begin
          errors++;
          $display("FAIL abort_ptr: got %0d exp 2", bus.activeChannel);
        end
      end
    end
    bus.assertDACK = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.DREQ = 4'b0001;
    bus.HLDA = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.assertDACK   = (c >= 2);
      bus.deassertDACK = (c >= 2);
      @(negedge CLK);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL simul_model c=%0d: got %h exp %h", c, obs, exp_vec);
      end
      if (c == 2) begin
        checks++;
        if (bus.DACK !== 4'b1110 || bus.channelGranted !== 1'b1) begin
          errors++;
          $display("FAIL simul_granted: got %b/%b exp 1110/1", bus.DACK, bus.channelGranted);
        end
      end
      if (c == 3) begin
        checks++;
        if (bus.DACK !== 4'hF || bus.HRQ !== 1'b0) begin
          errors++;
          $display("FAIL simul_active: got %b/%b exp 1111/0", bus.DACK, bus.HRQ);
        end
      end
    end
    bus.assertDACK   = 1'b0;
    bus.deassertDACK = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.DREQ = 4'b0100;
    bus.HLDA = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.assertDACK = (c == 2);
      @(negedge CLK);
    end
    bus.assertDACK = 1'b0;
    checks++;
    if (bus.DACK !== 4'b1011) begin
      errors++;
      $display("FAIL areset_pre: got %b exp 1011", bus.DACK);
    end
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if (obs !== 8'h0F) begin
      errors++;
      $display("FAIL areset_clear: got %h exp %h", obs, 8'h0F);
    end
    bus.DREQ = 4'b0000;
    #1;
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      bus.DREQ         = 4'($urandom_range(15, 0));
      bus.maskReg      = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'b0000;
      bus.HLDA         = ($urandom_range(9, 0) != 0);
      bus.assertDACK   = ($urandom_range(2, 0) == 0);
      bus.deassertDACK = ($urandom_range(2, 0) == 0);
      if ($urandom_range(19, 0) == 0) bus.rotatingPriority = ~bus.rotatingPriority;
      if ($urandom_range(49, 0) == 0) bus.dreqSenseLow = ~bus.dreqSenseLow;
      if ($urandom_range(29, 0) == 0) bus.dackSenseHigh = ~bus.dackSenseHigh;
      @(negedge CLK);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL random c=%0d: got %h exp %h", c, obs, exp_vec);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESET  = 1'b1;
    set_idle_inputs();
    test_reset();
    test_fixed();
    test_rotating();
    test_mask_polarity();
    test_withdraw();
    test_abort();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
Consumer end of the DMA internal timing-and-control handshake: receives assertDACK/deassertDACK and arbitrates external DREQ lines.
- Raises HRQ to the CPU, waits for HLDA and latches the winning channel.
- Drives DACK for that channel on command from timing-and-control.
- Sits between the DREQ/DACK pins, the command/mask registers in the datapath, and the timing-and-control FSM.

Parameters:
NUM_CHANNELS, 4, number of DMA channels (the design is exercised at 4)
CH_W, $clog2(NUM_CHANNELS), channel index width

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous reset, active-high
DREQ  input  NUM_CHANNELS  channel requests, polarity set by dreqSenseLow
HLDA  input  1  hold acknowledge from CPU
assertDACK  input  1  one-cycle pulse from timing-and-control: drive DACK for latched channel
deassertDACK  input  1  one-cycle pulse from timing-and-control: end of service
maskReg  input  NUM_CHANNELS  1 = channel masked
rotatingPriority  input  1  command bit: 1 = rotating, 0 = fixed (ch0 highest)
dreqSenseLow  input  1  command bit: 1 = DREQ active-low
dackSenseHigh  input  1  command bit: 1 = DACK active-high
HRQ  output  1  hold request to CPU
DACK  output  NUM_CHANNELS  channel acknowledges, polarity set by dackSenseHigh
activeChannel  output  CH_W  latched winning channel
channelGranted  output  1  high in GRANTED and ACTIVE; tells timing-and-control a cycle may start

Behaviour:
Clock and reset: one clock CLK; RESET is asynchronous and active-high.

Effective request:
- effReq = (dreqSenseLow ? ~DREQ : DREQ) & ~maskReg, evaluated each cycle.

State machine:
- IDLE -> REQUEST: when effReq != 0. Latch the winner into activeChannel; HRQ high the next cycle.
  - Fixed mode: lowest index wins.
  - Rotating mode: search starts at priPtr and wraps modulo NUM_CHANNELS.
- REQUEST:
  - HLDA=1 -> GRANTED.
  - If effReq[activeChannel] drops before HLDA -> IDLE and HRQ low next cycle. No re-arbitration in the same cycle.
- GRANTED: channelGranted=1. assertDACK -> ACTIVE. deassertDACK alone is ignored.
- ACTIVE: DACK[activeChannel] is active.
  - deassertDACK -> IDLE. DACK inactive and HRQ low next cycle.
  - Rotating mode only: priPtr <= (activeChannel+1) mod NUM_CHANNELS.
- HLDA falling in GRANTED or ACTIVE -> abort to IDLE. DACK inactive, HRQ low next cycle, priPtr unchanged.
- assertDACK and deassertDACK in the same cycle:
  - In GRANTED: go to ACTIVE.
  - In ACTIVE: deassertDACK wins.

Latency:
- Request in cycle n -> HRQ at n+1.
- HLDA at m -> channelGranted at m+1.
- assertDACK at k -> DACK at k+1.
- deassertDACK at j -> DACK/HRQ inactive at j+1.

Latched state during service:
- maskReg, DREQ and rotatingPriority changes do not affect activeChannel or DACK while in GRANTED/ACTIVE.
- A new request is arbitrated only on return to IDLE, with earliest HRQ re-assertion at j+2.
- Changing rotatingPriority keeps priPtr; fixed mode ignores it.

DACK encoding:
- Internal one-hot ackVec is registered.
- DACK = dackSenseHigh ? ackVec : ~ackVec. The polarity change is combinational.

Reset values:
- state=IDLE, HRQ=0, ackVec=0 (so DACK = all inactive: 4'hF when dackSenseHigh=0), activeChannel=0, channelGranted=0, priPtr=0.
- Reset mid-service clears immediately (asynchronous).

Decomposition:
- dma_pkg holds:
  - NUM_CHANNELS default
  - chan_t (CH_W-bit channel index)
  - arb_state_t enum {IDLE, REQUEST, GRANTED, ACTIVE}
- One combinational sub-module, dma_priority_encoder. Inputs: effReq, priPtr, rotatingPriority. Outputs: winner index and valid.

Test Plan:
- Fixed mode: DREQ=4'b0110, mask 0, HLDA after 3 cycles, assertDACK, deassertDACK -> HRQ at n+1; activeChannel=1; DACK=4'b1101 (active-low) at k+1; all 4'hF at j+1.
- Rotating mode: DREQ=4'b1111 held, four full services -> grant order 0,1,2,3, then 0 again; priPtr advances after each deassertDACK.
- Masking/polarity: maskReg=4'b0001, dreqSenseLow=1, DREQ=4'b1100 -> effReq=4'b0010, winner ch1; dackSenseHigh=1 -> DACK=4'b0010.
- Request withdrawn: DREQ[2] pulses 2 cycles with HLDA held low -> HRQ rises then falls; state back to IDLE; DACK never active.
- Abort and simultaneity:
  - HLDA drops in ACTIVE on ch3 -> DACK inactive, HRQ low next cycle, priPtr unchanged.
  - Separately, assertDACK+deassertDACK together in GRANTED -> ACTIVE.
- RESET asserted asynchronously mid-ACTIVE -> HRQ=0, DACK=4'hF, channelGranted=0 without waiting for a CLK edge.
